// File: rtl/mole_hit_scorer_if.sv
// Signal bundle between the whack-a-mole game logic and the hit scorer.
// The master drives switches, mole pattern and game phase; the slave returns debounced levels and scoring.
interface mole_hit_scorer_if;
    logic [4:0] switch_in;
    logic [4:0] mole_in;
    logic       game_active;
    logic [4:0] switch_clean;
    logic       hit_pulse;
    logic       miss_pulse;
    logic [3:0] score_tens;
    logic [3:0] score_ones;
    logic [7:0] miss_count;

    modport master (
        output switch_in, mole_in, game_active,
        input  switch_clean, hit_pulse, miss_pulse, score_tens, score_ones, miss_count
    );

    modport slave (
        input  switch_in, mole_in, game_active,
        output switch_clean, hit_pulse, miss_pulse, score_tens, score_ones, miss_count
    );
endinterface

// File: rtl/mole_hit_scorer.sv
// Switch synchronizer/debouncer plus hit/miss scoring FSM for the whack-a-mole game.
//   state  | meaning
//   IDLE   | game not running; score and miss count frozen for display
//   ARMED  | a strike is scored as a hit (matches mole) or a miss
//   LOCKED | mole already hit; strikes ignored until the mole pattern changes
module mole_hit_scorer #(
    parameter int DEBOUNCE_CYCLES = 100000,
    parameter int SCORE_MAX       = 99
) (
    input  logic               clk,
    input  logic               reset,
    mole_hit_scorer_if.slave   bus
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_TC   = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [3:0]       TENS_MAX = 4'(SCORE_MAX / 10);
    localparam logic [3:0]       ONES_MAX = 4'(SCORE_MAX % 10);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ARMED  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [4:0]       sync1_q, sync1_d;
    logic [4:0]       sync2_q, sync2_d;
    logic [4:0]       clean_q, clean_d;
    logic [4:0]       clean_prev_q, clean_prev_d;
    logic [CNT_W-1:0] cnt_q [5];
    logic [CNT_W-1:0] cnt_d [5];

    logic [4:0] mole_prev_q, mole_prev_d;
    logic       game_prev_q, game_prev_d;
    logic       hit_pulse_q, hit_pulse_d;
    logic       miss_pulse_q, miss_pulse_d;
    logic [3:0] score_tens_q, score_tens_d;
    logic [3:0] score_ones_q, score_ones_d;
    logic [7:0] miss_count_q, miss_count_d;

    logic [4:0] strike;
    logic       strike_any;
    logic       hit_any;
    logic       game_rise;

    // Input synchronizer and per-bit debounce counters
    always_comb begin
        sync1_d      = bus.switch_in;
        sync2_d      = sync1_q;
        clean_d      = clean_q;
        clean_prev_d = clean_q;
        for (int i = 0; i < 5; i++) begin
            cnt_d[i] = '0;
            if (sync2_q[i] != clean_q[i]) begin
                if (cnt_q[i] == CNT_TC) begin
                    clean_d[i] = sync2_q[i];
                end else begin
                    cnt_d[i] = cnt_q[i] + 1'b1;
                end
            end
        end
    end

    assign strike     = clean_q ^ clean_prev_q;
    assign strike_any = |strike;
    assign hit_any    = |(strike & bus.mole_in);
    assign game_rise  = bus.game_active & ~game_prev_q;

    always_comb begin
        state_d      = state_q;
        mole_prev_d  = bus.mole_in;
        game_prev_d  = bus.game_active;
        hit_pulse_d  = 1'b0;
        miss_pulse_d = 1'b0;
        score_tens_d = score_tens_q;
        score_ones_d = score_ones_q;
        miss_count_d = miss_count_q;

        if (!bus.game_active) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (game_rise) begin
                        state_d      = ARMED;
                        score_tens_d = 4'd0;
                        score_ones_d = 4'd0;
                        miss_count_d = 8'd0;
                    end
                end
                ARMED: begin
                    if (hit_any) begin
                        state_d     = LOCKED;
                        hit_pulse_d = 1'b1;
                        if (!(score_tens_q == TENS_MAX && score_ones_q == ONES_MAX)) begin
                            if (score_ones_q == 4'd9) begin
                                score_ones_d = 4'd0;
                                score_tens_d = score_tens_q + 4'd1;
                            end else begin
                                score_ones_d = score_ones_q + 4'd1;
                            end
                        end
                    end else if (strike_any) begin
                        miss_pulse_d = 1'b1;
                        if (miss_count_q != 8'hFF) begin
                            miss_count_d = miss_count_q + 8'd1;
                        end
                    end
                end
                LOCKED: begin
                    // A strike in the same cycle as the mole change is dropped
                    if (bus.mole_in != mole_prev_q) begin
                        state_d = ARMED;
                    end
                end
                default: state_d = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            sync1_q      <= '0;
            sync2_q      <= '0;
            clean_q      <= '0;
            clean_prev_q <= '0;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= '0;
            end
            mole_prev_q  <= '0;
            game_prev_q  <= 1'b0;
            hit_pulse_q  <= 1'b0;
            miss_pulse_q <= 1'b0;
            score_tens_q <= 4'd0;
            score_ones_q <= 4'd0;
            miss_count_q <= 8'd0;
        end else begin
            state_q      <= state_d;
            sync1_q      <= sync1_d;
            sync2_q      <= sync2_d;
            clean_q      <= clean_d;
            clean_prev_q <= clean_prev_d;
            for (int i = 0; i < 5; i++) begin
                cnt_q[i] <= cnt_d[i];
            end
            mole_prev_q  <= mole_prev_d;
            game_prev_q  <= game_prev_d;
            hit_pulse_q  <= hit_pulse_d;
            miss_pulse_q <= miss_pulse_d;
            score_tens_q <= score_tens_d;
            score_ones_q <= score_ones_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign bus.switch_clean = clean_q;
    assign bus.hit_pulse    = hit_pulse_q;
    assign bus.miss_pulse   = miss_pulse_q;
    assign bus.score_tens   = score_tens_q;
    assign bus.score_ones   = score_ones_q;
    assign bus.miss_count   = miss_count_q;

endmodule
